filt_wb_writer: RTL and testbench

Write-back side of the 1by1 word filter accelerators: accepts 128-bit result words from the filter datapath over a valid/ready handshake, buffers them in a small FIFO, and issues one memory write per word at address offset + word index. Where the read side counts words out of memory, this block counts them back in. File size is measured in 128-bit words, and addresses are word-granular.

---
 rtl/filt_wb_writer.sv | 107 ++++++++++
 tb/tb_filt_wb_writer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/filt_wb_writer.sv
// filt_wb_writer: write-back stage for the 1by1 word filters.
// Accepts result words over valid/ready, buffers them in a small FIFO and
// issues one memory write per word at offset + word index.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | accepting words and writing them out
// DONE  | all filesize words written; waiting for next start
module filt_wb_writer #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       offset,
  input  logic [31:0]       filesize,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] fifo_mem [DEPTH];
  logic [AW:0]       wptr, rptr;
  logic [31:0]       offset_q, size_q, acc_cnt, wr_cnt;
  logic              running, full, empty, push, pop, take_start;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty      = (wptr == rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign running    = (state_q == RUN);
  assign in_ready   = running && !full && (acc_cnt < size_q);
  assign mem_we     = running && !empty;
  assign push       = in_valid && in_ready;
  assign pop        = mem_we && mem_ack;
  assign take_start = start && (state_q != RUN);

  assign mem_addr  = offset_q + wr_cnt;
  assign mem_wdata = mem_we ? fifo_mem[rptr[AW-1:0]] : '0;
  assign busy      = running;
  assign done      = (state_q == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the final completion moves to DONE on the following cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (filesize == 32'd0) ? DONE : RUN;
      end
      RUN: begin
        if (pop && ((wr_cnt + 32'd1) == size_q)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job parameters, word counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q <= '0;
      size_q   <= '0;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else if (take_start) begin
      offset_q <= offset;
      size_q   <= filesize;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      if (push) begin
        acc_cnt <= acc_cnt + 32'd1;
        wptr    <= wptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        wr_cnt <= wr_cnt + 32'd1;
        rptr   <= rptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_filt_wb_writer.sv
// Testbench for filt_wb_writer: randomized traffic against a queue-based
// reference model of the expected write stream.
module tb_filt_wb_writer;

  localparam int DEPTH  = 4;
  localparam int WORD_W = 128;

  logic              clk = 1'b0;
  logic              reset, start, in_valid, mem_ack;
  logic [31:0]       offset, filesize;
  logic [WORD_W-1:0] in_data;
  logic              in_ready, mem_we, busy, done;
  logic [31:0]       mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  filt_wb_writer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .clk(clk), .reset(reset), .start(start), .offset(offset), .filesize(filesize),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Runs one complete file. Inputs change and outputs are sampled at the
  // falling edge. Expected in_ready/mem_we/address/data/done come from the
  // model: queue of accepted words, count accepted, count written.
  task automatic run_file(input string name, input logic [31:0] off, input logic [31:0] sz,
                          input int vp, input int ap, input int ack_hold,
                          input bit seqd, input bit stray);
    logic [WORD_W-1:0] q[$];
    logic [31:0] acc, wr, exp_addr;
    bit exp_ready, exp_we, fin;
    int cyc;
    acc = 0; wr = 0; fin = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1; offset = off; filesize = sz; in_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== (sz != 0) || done !== (sz == 0))
      $display("FAIL %s start_resp busy=%b done=%b expected busy=%b done=%b",
               name, busy, done, sz != 0, sz == 0);
    while (!fin && cyc < 2000) begin
      if (wr == sz) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL %s done_state done=%b busy=%b in_ready=%b mem_we=%b expected 1 0 0 0",
                   name, done, busy, in_ready, mem_we);
        end
        fin = 1;
      end else begin
        exp_ready = (acc < sz) && ((acc - wr) < DEPTH);
        exp_we    = (acc != wr);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== exp_ready || mem_we !== exp_we) begin
          errors++;
          $display("FAIL %s ctrl cyc=%0d busy=%b done=%b in_ready=%b mem_we=%b expected 1 0 %b %b",
                   name, cyc, busy, done, in_ready, mem_we, exp_ready, exp_we);
        end
        if (exp_we) begin
          exp_addr = off + wr;
          checks++;
          if (mem_addr !== exp_addr || mem_wdata !== q[0]) begin
            errors++;
            $display("FAIL %s write%0d addr=%h data=%h expected addr=%h data=%h",
                     name, wr, mem_addr, mem_wdata, exp_addr, q[0]);
          end
        end else begin
          checks++;
          if (mem_wdata !== '0) begin
            errors++;
            $display("FAIL %s idle_wdata data=%h expected 0", name, mem_wdata);
          end
        end
        in_valid = ($urandom_range(99) < vp);
        in_data  = seqd ? WORD_W'(acc + 1) : {$urandom, $urandom, $urandom, $urandom};
        mem_ack  = (cyc >= ack_hold) && ($urandom_range(99) < ap);
        start    = stray && (cyc == 1);
        if (start) begin
          offset = 32'hDEAD0000; filesize = 32'd99;
        end
        if (in_valid && exp_ready) begin
          q.push_back(in_data);
          acc++;
        end
        if (exp_we && mem_ack) begin
          void'(q.pop_front());
          wr++;
        end
        cyc++;
        @(negedge clk);
        start = 1'b0;
      end
    end
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout written=%0d expected %0d", name, wr, sz);
    end
    in_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_hold done=%b busy=%b expected 1 0", name, done, busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 ||
        mem_wdata !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s rdy=%b we=%b addr=%h wdata=%h busy=%b done=%b expected all 0",
               name, in_ready, mem_we, mem_addr, mem_wdata, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; offset = '0; filesize = '0;
    in_data = '0; in_valid = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_basic();
    run_file("basic", 32'h100, 32'd4, 100, 100, 0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_file("backpressure", 32'h200, 32'd8, 100, 100, 10, 1'b1, 1'b0);
  endtask

  task automatic test_zero();
    run_file("zero_size", 32'h300, 32'd0, 100, 100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_file("wrap", 32'hFFFF_FFFE, 32'd3, 100, 100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int acks, cyc;
    acks = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1; offset = 32'h500; filesize = 32'd8;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; mem_ack = 1'b1;
    while (acks < 2 && cyc < 50) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      if (mem_we) acks++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (acks < 2) begin
      errors++;
      $display("FAIL reset_mid acks=%0d expected 2", acks);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_outputs");
    reset = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    run_file("after_reset", 32'h40, 32'd2, 100, 100, 0, 1'b0, 1'b0);
  endtask

  task automatic test_overrun();
    run_file("overrun_stray", 32'h600, 32'd2, 100, 100, 0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_file("random", {$urandom}, 32'($urandom_range(20, 1)),
               $urandom_range(100, 30), $urandom_range(100, 30), 0, 1'b0, (i % 3) == 0);
    end
  endtask

  task automatic test_back_to_back();
    run_file("b2b_a", 32'h1000, 32'd5, 100, 100, 0, 1'b0, 1'b0);
    run_file("b2b_b", 32'h2000, 32'd6, 70, 60, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_wrap();
    test_reset_mid();
    test_overrun();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
